// File: rtl/acc_pkg.sv
// Shared definitions for the dot-product accumulator: state encoding and
// default widths.
package acc_pkg;

  localparam int ACC_W_DEF = 40;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } acc_state_e;

endpackage : acc_pkg

// File: rtl/dot_accumulator.sv
// Sums Len consecutive valid-tagged 32-bit results into an ACC_W-bit total
// with a sticky carry flag, presented on a valid/ready result port.
module dot_accumulator
  import acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [LEN_W-1:0]  Len,
  output logic              Busy,
  input  logic [31:0]       InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [ACC_W-1:0]  Result,
  output logic              Overflow,
  output logic              ResultValid,
  input  logic              ResultReady
);

  // Adds a zero-extended 32-bit term; bit ACC_W of the return is the carry-out.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                             input logic [31:0] term);
    logic [ACC_W:0] ext_acc;
    logic [ACC_W:0] ext_term;
    ext_acc  = {1'b0, acc};
    ext_term = {{(ACC_W-31){1'b0}}, term};
    return ext_acc + ext_term;
  endfunction

  acc_state_e       r_state;
  acc_state_e       w_next;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_rem;
  logic             r_ovf;
  logic             w_beat;
  logic [ACC_W:0]   w_sum;

  assign w_beat = InValid && (r_state == S_ACCUM);
  assign w_sum  = acc_add(r_acc, InData);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The encoding 2'd3 is unreachable in normal operation; it falls back to IDLE.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = Start ? ((Len == '0) ? S_DONE : S_ACCUM) : S_IDLE;
      S_ACCUM: w_next = (w_beat && (r_rem == LEN_W'(1))) ? S_DONE : S_ACCUM;
      S_DONE:  w_next = ResultReady ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_acc <= '0;
      r_rem <= '0;
      r_ovf <= 1'b0;
    end else if ((r_state == S_IDLE) && Start) begin
      r_acc <= '0;
      r_rem <= Len;
      r_ovf <= 1'b0;
    end else if (w_beat) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_rem <= r_rem - LEN_W'(1);
      r_ovf <= r_ovf | w_sum[ACC_W];
    end
  end

  assign Busy        = (r_state == S_ACCUM) || (r_state == S_DONE);
  assign InReady     = (r_state == S_ACCUM);
  assign ResultValid = (r_state == S_DONE);
  assign Result      = r_acc;
  assign Overflow    = r_ovf;

endmodule : dot_accumulator

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: two widths (40 and 33 bits) share one
// stimulus stream and are checked every cycle against a true-sum model.
module tb_dot_accumulator;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  Len;
  logic [31:0] InData;
  logic        InValid;
  logic        ResultReady;

  logic        busy_a, inrdy_a, ovf_a, rv_a;
  logic [39:0] res_a;
  logic        busy_b, inrdy_b, ovf_b, rv_b;
  logic [32:0] res_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 summing, 2 holding; m_sum is the exact (unwrapped) sum.
  int          m_mode = 0;
  int          m_rem  = 0;
  logic [63:0] m_sum  = '0;

  always #5 Clk = ~Clk;

  dot_accumulator #(.ACC_W(40), .LEN_W(8)) u_dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len), .Busy(busy_a),
    .InData(InData), .InValid(InValid), .InReady(inrdy_a), .Result(res_a),
    .Overflow(ovf_a), .ResultValid(rv_a), .ResultReady(ResultReady)
  );

  dot_accumulator #(.ACC_W(33), .LEN_W(8)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len), .Busy(busy_b),
    .InData(InData), .InValid(InValid), .InReady(inrdy_b), .Result(res_b),
    .Overflow(ovf_b), .ResultValid(rv_b), .ResultReady(ResultReady)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_mode <= 0;
      m_rem  <= 0;
      m_sum  <= '0;
    end else begin
      case (m_mode)
        0: if (Start) begin
          m_sum <= '0;
          if (Len == 8'd0) m_mode <= 2;
          else begin
            m_mode <= 1;
            m_rem  <= int'(Len);
          end
        end
        1: if (InValid) begin
          m_sum <= m_sum + {32'd0, InData};
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_mode <= 2;
        end
        default: if (ResultReady) m_mode <= 0;
      endcase
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy_a",  {63'd0, busy_a},  {63'd0, m_mode != 0});
      check("inrdy_a", {63'd0, inrdy_a}, {63'd0, m_mode == 1});
      check("rv_a",    {63'd0, rv_a},    {63'd0, m_mode == 2});
      check("res_a",   {24'd0, res_a},   {24'd0, m_sum[39:0]});
      check("ovf_a",   {63'd0, ovf_a},   {63'd0, (m_sum >> 40) != 0});
      check("busy_b",  {63'd0, busy_b},  {63'd0, m_mode != 0});
      check("rv_b",    {63'd0, rv_b},    {63'd0, m_mode == 2});
      check("res_b",   {31'd0, res_b},   {31'd0, m_sum[32:0]});
      check("ovf_b",   {63'd0, ovf_b},   {63'd0, (m_sum >> 33) != 0});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] n);
    Start = 1'b1;
    Len   = n;
    tick();
    Start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    InValid = 1'b1;
    InData  = d;
    tick();
    InValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Len = '0; InData = '0; InValid = 1'b0; ResultReady = 1'b0;
    tick(); tick();
    check("rst_busy", {63'd0, busy_a}, 64'd0);
    check("rst_rv",   {63'd0, rv_a},   64'd0);
    check("rst_res",  {24'd0, res_a},  64'd0);
    Reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // Asynchronous reset in the middle of a 4-term run.
    start_run(8'd4);
    beat(32'd1);
    beat(32'd2);
    check("mid_res", {24'd0, res_a}, 64'd3);
    Reset = 1'b1;
    #1;
    check("arst_busy",  {63'd0, busy_a},  64'd0);
    check("arst_inrdy", {63'd0, inrdy_a}, 64'd0);
    check("arst_res",   {24'd0, res_a},   64'd0);
    check("arst_rv",    {63'd0, rv_a},    64'd0);
    check("arst_ovf",   {63'd0, ovf_a},   64'd0);
    tick(); tick();
    Reset = 1'b0;
    tick();
    start_run(8'd2);
    beat(32'd5);
    beat(32'd7);
    check("post_rst_res", {24'd0, res_a}, 64'd12);
    ResultReady = 1'b1; tick(); ResultReady = 1'b0;

    // Contiguous 3-term run; result held while consumer stalls.
    start_run(8'd3);
    check("busy_after_start", {63'd0, busy_a}, 64'd1);
    beat(32'd3);
    beat(32'd11);
    check("rv_before_last", {63'd0, rv_a}, 64'd0);
    beat(32'd18);
    check("rv_lat4", {63'd0, rv_a}, 64'd1);
    check("res_32",  {24'd0, res_a}, 64'd32);
    check("ovf_32",  {63'd0, ovf_a}, 64'd0);
    check("inrdy_done", {63'd0, inrdy_a}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_rv",  {63'd0, rv_a},  64'd1);
      check("hold_res", {24'd0, res_a}, 64'd32);
    end
    ResultReady = 1'b1; tick(); ResultReady = 1'b0;
    check("idle_keeps_res", {24'd0, res_a}, 64'd32);
    check("idle_rv", {63'd0, rv_a}, 64'd0);

    // Stalled stream: data presented with InValid low is not summed.
    start_run(8'd2);
    beat(32'd100);
    InData = 32'd999; tick(); tick();
    beat(32'd200);
    check("res_300", {24'd0, res_a}, 64'd300);
    ResultReady = 1'b1; tick(); ResultReady = 1'b0;

    // Zero-length run with consumer already ready: one-cycle ResultValid.
    ResultReady = 1'b1;
    start_run(8'd0);
    check("len0_rv",  {63'd0, rv_a},  64'd1);
    check("len0_res", {24'd0, res_a}, 64'd0);
    tick();
    check("len0_rv_drop", {63'd0, rv_a}, 64'd0);
    ResultReady = 1'b0;

    // Start pulses during ACCUM, DONE and the handshake cycle are ignored.
    start_run(8'd2);
    Start = 1'b1; Len = 8'd5;
    beat(32'd10);
    beat(32'd20);
    tick();
    check("ign_res", {24'd0, res_a}, 64'd30);
    check("ign_rv",  {63'd0, rv_a},  64'd1);
    ResultReady = 1'b1;
    tick();
    Start = 1'b0; ResultReady = 1'b0;
    check("ign_hs_busy", {63'd0, busy_a}, 64'd0);
    check("ign_hs_res",  {24'd0, res_a},  64'd30);
    tick();

    // Carry-out: 33-bit wraps and flags, 40-bit does not.
    start_run(8'd3);
    beat(32'hFFFF_FFFF);
    beat(32'hFFFF_FFFF);
    beat(32'hFFFF_FFFF);
    check("w33_res", {31'd0, res_b}, 64'h0_FFFF_FFFD);
    check("w33_ovf", {63'd0, ovf_b}, 64'd1);
    check("w40_res", {24'd0, res_a}, 64'h2_FFFF_FFFD);
    check("w40_ovf", {63'd0, ovf_a}, 64'd0);
    ResultReady = 1'b1; tick(); ResultReady = 1'b0;
    tick(); tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dot_accumulator
